// File: rtl/conv_pkg.sv
// Shared types and default sizes for the convolution slice row.
// Used by the weight loader and the slices it drives.
package conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } loader_state_t;

    localparam int DEF_MAC_NB       = 3;
    localparam int DEF_SLICE_NB     = 3;
    localparam int DEF_WEIGHT_WIDTH = 16;

endpackage

// File: rtl/weight_loader.sv
// Streams one kernel of weights onto a shared bus with one-hot strobes.
// Word k lands on slice k/MAC_NB, MAC k%MAC_NB, one cycle after acceptance.
module weight_loader
    import conv_pkg::*;
#(
    parameter int MAC_NB       = DEF_MAC_NB,
    parameter int SLICE_NB     = DEF_SLICE_NB,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WEIGHT_WIDTH-1:0]    weight_in,
    input  logic                       weight_in_valid,
    output logic                       weight_in_ready,
    output logic [WEIGHT_WIDTH-1:0]    weight,
    output logic [MAC_NB*SLICE_NB-1:0] weight_valid,
    output logic                       busy,
    output logic                       loaded
);

    localparam int KERNEL_NB = MAC_NB * SLICE_NB;
    localparam int CNT_W     = $clog2(KERNEL_NB);

    localparam logic [KERNEL_NB-1:0] STROBE_ONE = KERNEL_NB'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(KERNEL_NB - 1);

    loader_state_t           r_state;
    loader_state_t           w_state_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [WEIGHT_WIDTH-1:0] r_weight;
    logic [KERNEL_NB-1:0]    r_strobe;
    logic                    r_loaded;
    logic                    w_ready;
    logic                    w_hs;
    logic                    w_last;

    // Ready never depends on valid; a start pulse blocks acceptance that cycle.
    assign w_ready = (r_state == LOAD) & ~start;
    assign w_hs    = weight_in_valid & w_ready;
    assign w_last  = (r_count == CNT_LAST);

    // State and word counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state: start (re)opens a load, last accepted word closes it.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_count_nxt = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    w_count_nxt = '0;
                end else if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Registered bus: weight holds between strobes, strobe lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
            r_strobe <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_strobe <= w_hs ? (STROBE_ONE << r_count) : '0;
            r_loaded <= w_hs & w_last;
            if (w_hs) begin
                r_weight <= weight_in;
            end
        end
    end

    assign weight_in_ready = w_ready;
    assign weight          = r_weight;
    assign weight_valid    = r_strobe;
    assign busy            = (r_state == LOAD);
    assign loaded          = r_loaded;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a kernel-level reference model.
// Every falling edge compares all outputs against the model.
module tb_weight_loader;

    localparam int KN = 9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   weight_in;
    logic          weight_in_valid;
    logic          weight_in_ready;
    logic [15:0]   weight;
    logic [KN-1:0] weight_valid;
    logic          busy;
    logic          loaded;

    weight_loader #(
        .MAC_NB       (3),
        .SLICE_NB     (3),
        .WEIGHT_WIDTH (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .weight_in       (weight_in),
        .weight_in_valid (weight_in_valid),
        .weight_in_ready (weight_in_ready),
        .weight          (weight),
        .weight_valid    (weight_valid),
        .busy            (busy),
        .loaded          (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a kernel load is "open" after start; accepted
    // words are numbered 0..8 and word n appears next cycle at bit n.
    bit            m_open;
    int            m_idx;
    logic [15:0]   m_w;
    logic [KN-1:0] m_strobe;
    bit            m_loaded;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open   = 0;
            m_idx    = 0;
            m_w      = '0;
            m_strobe = '0;
            m_loaded = 0;
        end else begin
            m_strobe = '0;
            m_loaded = 0;
            if (start) begin
                m_open = 1;
                m_idx  = 0;
            end else if (m_open && weight_in_valid) begin
                m_w          = weight_in;
                m_strobe[m_idx] = 1'b1;
                m_loaded     = (m_idx == KN - 1);
                m_idx        = m_idx + 1;
                if (m_idx == KN) begin
                    m_open = 0;
                    m_idx  = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("weight", 32'(weight), 32'(m_w));
        chk("weight_valid", 32'(weight_valid), 32'(m_strobe));
        chk("busy", 32'(busy), 32'(m_open));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("ready", 32'(weight_in_ready), 32'(m_open & ~start));
    end

    // Strobe log for literal sequence checks.
    logic [24:0] log_q[$];
    int          n_loaded;

    always @(negedge clk) begin
        if (weight_valid != '0) log_q.push_back({weight_valid, weight});
        if (loaded) n_loaded++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_q.delete();
        n_loaded = 0;
    endtask

    task automatic send(input logic [15:0] w);
        weight_in_valid = 1'b1;
        weight_in       = w;
        tick();
        weight_in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_entry(input string name, input int i,
                             input logic [8:0] s, input logic [15:0] w);
        if (i < log_q.size())
            chk(name, 32'(log_q[i]), 32'({s, w}));
        else
            chk(name, 32'(log_q.size()), 32'(i + 1));
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        weight_in       = '0;
        weight_in_valid = 1'b0;
        n_loaded        = 0;

        // Inputs toggling under reset.
        for (int i = 0; i < 4; i++) begin
            start           = i[0];
            weight_in_valid = 1'b1;
            weight_in       = 16'h1234 + 16'(i);
            tick();
        end
        chk("rst_weight", 32'(weight), 32'h0);
        chk("rst_wvalid", 32'(weight_valid), 32'h0);
        chk("rst_ready", 32'(weight_in_ready), 32'h0);
        start           = 1'b0;
        weight_in_valid = 1'b0;
        rst_n           = 1'b1;
        tick();

        // Back-to-back kernel.
        clear_log();
        do_start();
        chk("busy_after_start", 32'(busy), 32'h1);
        for (int i = 1; i <= 9; i++) begin
            weight_in_valid = 1'b1;
            weight_in       = 16'(i);
            tick();
        end
        weight_in_valid = 1'b0;
        chk("busy_drop", 32'(busy), 32'h0);
        chk("loaded_last", 32'(loaded), 32'h1);
        tick();
        tick();
        chk("b2b_count", 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            chk_entry("b2b_seq", i, 9'(1) << i, 16'(i + 1));
        chk("b2b_loaded", 32'(n_loaded), 32'd1);

        // Valid low every other cycle.
        clear_log();
        do_start();
        for (int i = 1; i <= 9; i++) begin
            send(16'(16'h0100 + i));
            weight_in = 16'hDEAD;
            tick();
        end
        tick();
        chk("gap_count", 32'(log_q.size()), 32'd9);
        chk_entry("gap_first", 0, 9'h001, 16'h0101);
        chk_entry("gap_last", 8, 9'h100, 16'h0109);
        chk("gap_hold", 32'(weight), 32'h0109);
        chk("gap_loaded", 32'(n_loaded), 32'd1);

        // Restart mid-load.
        do_start();
        for (int i = 0; i < 4; i++) send(16'(16'h0010 + i));
        start           = 1'b1;
        weight_in_valid = 1'b1;
        weight_in       = 16'h5555;
        tick();
        start = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) send(16'(16'hA000 + i));
        tick();
        chk("rs_first", 32'(log_q.size() > 0 ? log_q[0] : 25'h0),
            32'({9'h001, 16'hA000}));
        chk("rs_not_yet", 32'(n_loaded), 32'd0);
        send(16'hA008);
        tick();
        chk("rs_count", 32'(log_q.size()), 32'd9);
        chk("rs_loaded", 32'(n_loaded), 32'd1);

        // Valid held in IDLE.
        clear_log();
        weight_in_valid = 1'b1;
        weight_in       = 16'hBEEF;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_ready", 32'(weight_in_ready), 32'h0);
        weight_in_valid = 1'b0;
        chk("idle_strobes", 32'(log_q.size()), 32'd0);

        // Async reset mid-load.
        do_start();
        for (int i = 0; i < 4; i++) send(16'(16'h0200 + i));
        weight_in_valid = 1'b1;
        weight_in       = 16'h0204;
        tick();
        weight_in_valid = 1'b0;
        chk("pre_rst_strobe", 32'(weight_valid), 32'h010);
        rst_n = 1'b0;
        #1;
        chk("arst_weight", 32'(weight), 32'h0);
        chk("arst_wvalid", 32'(weight_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_loaded", 32'(loaded), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        do_start();
        for (int i = 0; i < 9; i++) send(16'(16'h0300 + i));
        tick();
        chk_entry("post_rst_first", 0, 9'h001, 16'h0300);
        chk("post_rst_count", 32'(log_q.size()), 32'd9);
        chk("post_rst_loaded", 32'(n_loaded), 32'd1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
